// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side signals of the store buffer.
// Handshake: a store or load request offered while stall is high is not
// consumed and must be re-offered. A drain write completes at every rising
// edge where dm_write_enable is high, and dm_write_enable already includes
// dm_ready.
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        stall;
  logic        st_misalign;
  logic        sb_empty;
  logic        dm_ready;
  logic        dm_write_enable;
  logic [31:0] dm_write_addr;
  logic [31:0] dm_write_data;
  logic [1:0]  dm_mem_size;

  // Pipeline and memory side: drives requests and dm_ready.
  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, dm_ready,
    input  stall, st_misalign, sb_empty,
    input  dm_write_enable, dm_write_addr, dm_write_data, dm_mem_size
  );

  // Store buffer side.
  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, dm_ready,
    output stall, st_misalign, sb_empty,
    output dm_write_enable, dm_write_addr, dm_write_data, dm_mem_size
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue between the MEM stage and the data memory write port.
// Stores are accepted without waiting on memory and drained oldest first, one
// per cycle. The MEM stage is stalled when the queue is full, or when a load
// hits a pending store at word granularity. Stores are never forwarded to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int IDX_W = 10
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave sb
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Entry storage.
  logic [31:0]      r_addr  [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic [1:0]       r_size  [DEPTH];
  logic [DEPTH-1:0] r_valid;

  // Queue control.
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_misalign;

  logic w_run;
  logic w_head_valid;
  logic w_misaligned;
  logic w_aligned_st;
  logic w_full_stall;
  logic w_ld_hit;
  logic w_hazard_stall;
  logic w_stall;
  logic w_enq;
  logic w_deq;
  logic w_show_head;
  logic w_unused_ld;

  // Only the word-index bits of the load address take part in the compare.
  assign w_unused_ld = ^{sb.ld_addr[31:IDX_W], sb.ld_addr[1:0]};

  // Outputs are forced idle for as long as reset is held low, even before the
  // first reset edge has cleared the registers.
  assign w_run        = rst;
  assign w_head_valid = (r_count != '0);

  // Alignment rules by access size; size 11 is always rejected.
  always_comb begin
    w_misaligned = 1'b0;
    case (sb.st_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = sb.st_addr[0];
      2'b10:   w_misaligned = (sb.st_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  assign w_aligned_st = sb.st_valid && !w_misaligned;

  // A dropped (misaligned) store never waits on a full queue. No full-bypass:
  // a dequeue in the same cycle does not free the slot early.
  assign w_full_stall = w_aligned_st && (r_count == FULL_CNT);

  // Word-granularity hazard compare against every live entry, head included.
  always_comb begin
    w_ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i][IDX_W-1:2] == sb.ld_addr[IDX_W-1:2])) begin
        w_ld_hit = 1'b1;
      end
    end
  end

  // A load presented together with a store is ignored.
  assign w_hazard_stall = sb.ld_valid && !sb.st_valid && w_ld_hit;

  assign w_stall     = w_run && (w_full_stall || w_hazard_stall);
  assign w_deq       = w_run && w_head_valid && sb.dm_ready;
  assign w_enq       = w_run && w_aligned_st && !w_stall;
  assign w_show_head = w_run && w_head_valid;

  assign sb.stall           = w_stall;
  assign sb.st_misalign     = r_misalign;
  assign sb.sb_empty        = !w_run || !w_head_valid;
  assign sb.dm_write_enable = w_deq;
  assign sb.dm_write_addr   = w_show_head ? r_addr[r_rd_ptr] : 32'h0;
  assign sb.dm_write_data   = w_show_head ? r_data[r_rd_ptr] : 32'h0;
  assign sb.dm_mem_size     = w_show_head ? r_size[r_rd_ptr] : 2'b00;

  // Payload capture at the tail; payload needs no reset since valid bits gate it.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wr_ptr] <= sb.st_addr;
      r_data[r_wr_ptr] <= sb.st_data;
      r_size[r_wr_ptr] <= sb.st_size;
    end
  end

  // Pointer, occupancy, valid-bit and misalign-pulse update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= sb.st_valid && w_misaligned;
      if (w_deq) begin
        r_rd_ptr           <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr]  <= 1'b0;
      end
      // Enqueue never targets the head slot being drained: when both happen
      // the queue is neither empty nor full, so the pointers differ.
      if (w_enq) begin
        r_wr_ptr           <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr]  <= 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic,
// each cycle checked against a queue-based reference model.
module tb_store_buffer;

  logic clk;
  logic rst;

  store_buffer_if u_if ();

  store_buffer #(.DEPTH(4), .PTR_W(2), .IDX_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (u_if.slave)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: pending stores as {addr, data, size}, oldest first.
  logic [65:0] exp_q[$];
  logic        exp_mis;
  bit          last_stall;
  int          n_tests;
  int          n_fail;

  function automatic bit is_mis(logic [31:0] a, logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit          hit;
    bit          acc_st;
    bit          e_stall;
    bit          e_we;
    logic [65:0] head;
    logic [31:0] ea;
    @(negedge clk);
    hit = 0;
    foreach (exp_q[k]) begin
      ea = exp_q[k][65:34];
      if (((ea / 4) % 256) == ((u_if.ld_addr / 4) % 256)) hit = 1;
    end
    acc_st  = u_if.st_valid && !is_mis(u_if.st_addr, u_if.st_size);
    e_stall = rst && ((acc_st && exp_q.size() == 4) ||
                      (!u_if.st_valid && u_if.ld_valid && hit));
    e_we    = rst && exp_q.size() != 0 && u_if.dm_ready;
    head    = (rst && exp_q.size() != 0) ? exp_q[0] : 66'h0;
    chk("stall",    {31'h0, u_if.stall},           {31'h0, e_stall});
    chk("dm_we",    {31'h0, u_if.dm_write_enable}, {31'h0, e_we});
    chk("sb_empty", {31'h0, u_if.sb_empty},        {31'h0, (!rst || exp_q.size() == 0)});
    chk("misalign", {31'h0, u_if.st_misalign},     {31'h0, exp_mis});
    chk("dm_addr",  u_if.dm_write_addr,            head[65:34]);
    chk("dm_data",  u_if.dm_write_data,            head[33:2]);
    chk("dm_size",  {30'h0, u_if.dm_mem_size},     {30'h0, head[1:0]});
    last_stall = e_stall;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      exp_mis = 1'b0;
    end else begin
      if (e_we) void'(exp_q.pop_front());
      if (acc_st && !e_stall) exp_q.push_back({u_if.st_addr, u_if.st_data, u_if.st_size});
      exp_mis = u_if.st_valid && is_mis(u_if.st_addr, u_if.st_size);
    end
    #1;
  endtask

  // Driver tasks.
  task automatic set_idle();
    u_if.st_valid = 1'b0;
    u_if.st_addr  = 32'h0;
    u_if.st_data  = 32'h0;
    u_if.st_size  = 2'b00;
    u_if.ld_valid = 1'b0;
    u_if.ld_addr  = 32'h0;
  endtask

  task automatic drive_st(logic [31:0] a, logic [31:0] d, logic [1:0] s);
    set_idle();
    u_if.st_valid = 1'b1;
    u_if.st_addr  = a;
    u_if.st_data  = d;
    u_if.st_size  = s;
  endtask

  task automatic drive_ld(logic [31:0] a);
    set_idle();
    u_if.ld_valid = 1'b1;
    u_if.ld_addr  = a;
  endtask

  // Offer a store until it is accepted, bounded.
  task automatic push_store(logic [31:0] a, logic [31:0] d, logic [1:0] s);
    int guard;
    drive_st(a, d, s);
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (last_stall && guard < 40);
    chk("push_bound", {31'h0, last_stall}, 32'h0);
    set_idle();
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_mis    = 1'b0;
    last_stall = 0;
    set_idle();
    u_if.dm_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: reset with stores queued discards them.
    push_store(32'h100, 32'h1111, 2'd2);
    push_store(32'h104, 32'h2222, 2'd2);
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    u_if.dm_ready = 1'b1;
    repeat (3) cycle();

    // 2: single word store reaches memory one cycle later.
    push_store(32'h10, 32'hDEADBEEF, 2'd2);
    repeat (2) cycle();

    // 3: fill with memory blocked, fifth store stalls until a slot frees.
    u_if.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_store(32'(i * 4), 32'hA0 + 32'(i), 2'd2);
    drive_st(32'h20, 32'hA4, 2'd2);
    repeat (3) cycle();
    u_if.dm_ready = 1'b1;
    cycle();
    cycle();
    set_idle();
    repeat (6) cycle();

    // 4: load hazard at word granularity, including an aliased address.
    u_if.dm_ready = 1'b0;
    push_store(32'h13, 32'h5A, 2'd0);
    drive_ld(32'h10);  cycle();
    drive_ld(32'h14);  cycle();
    drive_ld(32'h410); cycle();
    u_if.dm_ready = 1'b1;
    cycle();
    cycle();
    set_idle();
    cycle();

    // 5: misaligned stores are dropped with a one-cycle pulse.
    drive_st(32'h11, 32'h1, 2'd1); cycle(); set_idle(); cycle(); cycle();
    drive_st(32'h12, 32'h2, 2'd2); cycle(); set_idle(); cycle(); cycle();
    drive_st(32'h0,  32'h3, 2'd3); cycle(); set_idle(); cycle(); cycle();

    // 6: wrap-around with dm_ready toggling every cycle.
    for (int i = 0; i < 10; i++) begin
      drive_st(32'(i), 32'(i), 2'd0);
      for (int g = 0; g < 40; g++) begin
        u_if.dm_ready = ~u_if.dm_ready;
        cycle();
        if (!last_stall) break;
      end
    end
    set_idle();
    u_if.dm_ready = 1'b1;
    repeat (6) cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      set_idle();
      u_if.st_valid = ($urandom_range(0, 2) != 0);
      u_if.st_addr  = ($urandom_range(0, 1) << 10) | 32'($urandom_range(0, 31));
      u_if.st_data  = $urandom;
      u_if.st_size  = 2'($urandom_range(0, 3));
      u_if.ld_valid = ($urandom_range(0, 1) != 0);
      u_if.ld_addr  = ($urandom_range(0, 1) << 10) | 32'($urandom_range(0, 31));
      u_if.dm_ready = ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 60) != 0);
      cycle();
    end
    rst = 1'b1;
    set_idle();
    u_if.dm_ready = 1'b1;
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
